// File: rtl/resource_arbiter.sv
// resource_arbiter: round-robin front end for a shared, handle-indexed
// resource store. One access is in flight at a time. Each access walks
// IDLE -> ACCESS -> RESP, and its completion strobe is raised in RESP.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | pick the next pending port after last_grant; latch its fields
//   ACCESS | perform the store write (store/accumulate) or read into data_out
//   RESP   | raise read_ready / write_ack for the granted port
module resource_arbiter #(
  parameter int data_width   = 16,
  parameter int handle_width = 8,
  parameter int n_handles    = 256,
  parameter int n_ports      = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic [n_ports-1:0]              read_req,
  input  logic [n_ports-1:0]              write_req,
  input  logic [n_ports*handle_width-1:0] handle_in,
  input  logic [n_ports*data_width-1:0]   arg_a_in,
  input  logic [n_ports*data_width-1:0]   arg_b_in,
  output logic [data_width-1:0]           data_out,
  output logic [n_ports-1:0]              read_ready,
  output logic [n_ports-1:0]              write_ack,
  output logic                            busy
);

  localparam int port_w = (n_ports > 1) ? $clog2(n_ports) : 1;
  localparam int idx_w  = (n_handles > 1) ? $clog2(n_handles) : 1;
  localparam logic [port_w-1:0]     last_port    = port_w'(n_ports - 1);
  localparam logic [port_w:0]       port_count   = (port_w + 1)'(n_ports);
  localparam logic [handle_width:0] handle_limit = (handle_width + 1)'(n_handles);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                  state;
  logic [port_w-1:0]       last_grant;
  logic [port_w-1:0]       grant_port;
  logic [handle_width-1:0] lat_handle;
  logic [data_width-1:0]   lat_a;
  logic                    lat_accum;
  logic                    lat_write;

  logic [data_width-1:0]   mem [n_handles];

  logic [n_ports-1:0]      pending;
  logic                    pick_valid;
  logic [port_w-1:0]       pick;
  logic [port_w:0]         cand_w;
  logic [port_w-1:0]       cand_p;
  logic [handle_width-1:0] sel_handle;
  logic [data_width-1:0]   sel_a;
  logic [data_width-1:0]   sel_b;
  logic                    sel_write;

  logic                    in_range;
  logic [idx_w-1:0]        idx;
  logic                    mem_we;
  logic [data_width-1:0]   mem_wdata;

  // Round-robin search: first pending port starting just after last_grant.
  always_comb begin
    pending    = read_req | write_req;
    pick_valid = 1'b0;
    pick       = '0;
    cand_w     = '0;
    cand_p     = '0;
    for (int i = 0; i < n_ports; i++) begin
      cand_w = {1'b0, last_grant} + (port_w + 1)'(i + 1);
      if (cand_w >= port_count) begin
        cand_w = cand_w - port_count;
      end
      cand_p = cand_w[port_w-1:0];
      if (!pick_valid && pending[cand_p]) begin
        pick_valid = 1'b1;
        pick       = cand_p;
      end
    end
  end

  // Request fields of the winning port; write wins when both requests are up.
  always_comb begin
    sel_handle = handle_in[pick*handle_width +: handle_width];
    sel_a      = arg_a_in[pick*data_width +: data_width];
    sel_b      = arg_b_in[pick*data_width +: data_width];
    sel_write  = write_req[pick];
  end

  // Store addressing and write data; out-of-range handles never touch the store.
  always_comb begin
    in_range  = ({1'b0, lat_handle} < handle_limit);
    idx       = lat_handle[idx_w-1:0];
    mem_we    = enable && (state == ACCESS) && lat_write && in_range;
    mem_wdata = lat_accum ? (mem[idx] + lat_a) : lat_a;
  end

  // Control FSM: grant, latch, access, respond.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= last_port;
      grant_port <= '0;
      lat_handle <= '0;
      lat_a      <= '0;
      lat_accum  <= 1'b0;
      lat_write  <= 1'b0;
      data_out   <= '0;
    end else if (enable) begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant_port <= pick;
            last_grant <= pick;
            lat_handle <= sel_handle;
            lat_a      <= sel_a;
            lat_accum  <= |sel_b;
            lat_write  <= sel_write;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          if (!lat_write) begin
            data_out <= in_range ? mem[idx] : '0;
          end
          state <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Shared store; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx] <= mem_wdata;
    end
  end

  // Completion strobes and busy decode straight from the registered state.
  always_comb begin
    read_ready = '0;
    write_ack  = '0;
    if (state == RESP) begin
      if (lat_write) begin
        write_ack[grant_port] = 1'b1;
      end else begin
        read_ready[grant_port] = 1'b1;
      end
    end
    busy = (state != IDLE);
  end

endmodule

// File: tb/tb_resource_arbiter.sv
// tb_resource_arbiter: scenario tasks with a transaction-level model of the
// store and the round-robin grant order.
module tb_resource_arbiter;

  localparam int DW = 16;
  localparam int HW = 8;
  localparam int NH = 200;
  localparam int NP = 4;

  typedef logic [1:0] pidx_t;

  logic               clk = 1'b0;
  logic               reset;
  logic               enable;
  logic [NP-1:0]      read_req;
  logic [NP-1:0]      write_req;
  logic [NP*HW-1:0]   handle_in;
  logic [NP*DW-1:0]   arg_a_in;
  logic [NP*DW-1:0]   arg_b_in;
  logic [DW-1:0]      data_out;
  logic [NP-1:0]      read_ready;
  logic [NP-1:0]      write_ack;
  logic               busy;

  int checks = 0;
  int passes = 0;

  logic [DW-1:0] model_mem [256];
  bit            model_valid [256];
  int            model_last;

  resource_arbiter #(
    .data_width(DW),
    .handle_width(HW),
    .n_handles(NH),
    .n_ports(NP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .read_req(read_req),
    .write_req(write_req),
    .handle_in(handle_in),
    .arg_a_in(arg_a_in),
    .arg_b_in(arg_b_in),
    .data_out(data_out),
    .read_ready(read_ready),
    .write_ack(write_ack),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] model_read(int h);
    if (h < NH) return model_mem[8'(h)];
    return '0;
  endfunction

  function automatic void model_write(int h, logic [DW-1:0] a, logic [DW-1:0] b);
    if (h < NH) begin
      model_mem[8'(h)]   = (b == '0) ? a : model_mem[8'(h)] + a;
      model_valid[8'(h)] = 1'b1;
    end
  endfunction

  function automatic int next_grant(logic [NP-1:0] mask, int last);
    pidx_t pi;
    for (int k = 1; k <= NP; k++) begin
      pi = pidx_t'((last + k) % NP);
      if (mask[pi]) return int'(pi);
    end
    return -1;
  endfunction

  function automatic logic [2*NP-1:0] strobe_vec(bit wr, int p);
    if (wr) return (2*NP)'(1) << (NP + p);
    return (2*NP)'(1) << p;
  endfunction

  task automatic wait_idle(output bit to);
    to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (!busy) begin
        to = 1'b0;
        break;
      end
      tick();
    end
  endtask

  task automatic drive(int p, bit rd, bit wr, int h, logic [DW-1:0] a, logic [DW-1:0] b);
    read_req[pidx_t'(p)]  = rd;
    write_req[pidx_t'(p)] = wr;
    handle_in[p*HW +: HW] = HW'(h);
    arg_a_in[p*DW +: DW]  = a;
    arg_b_in[p*DW +: DW]  = b;
  endtask

  // One isolated request from port p; lat counts edges from request to strobe.
  task automatic run_op(int p, bit wr, int h, logic [DW-1:0] a, logic [DW-1:0] b,
                        output logic [DW-1:0] d, output int lat, output logic [2*NP-1:0] st);
    bit to;
    d   = '0;
    st  = '0;
    lat = 99;
    wait_idle(to);
    if (to) begin
      lat = 98;
    end else begin
      drive(p, !wr, wr, h, a, b);
      for (int i = 1; i <= 10; i++) begin
        tick();
        if ((read_ready | write_ack) != '0) begin
          lat = i;
          d   = data_out;
          st  = {write_ack, read_ready};
          break;
        end
      end
    end
    read_req[pidx_t'(p)]  = 1'b0;
    write_req[pidx_t'(p)] = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    enable    = 1'b1;
    read_req  = '0;
    write_req = '0;
    handle_in = '0;
    arg_a_in  = '0;
    arg_b_in  = '0;
    repeat (3) tick();
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passes++;
    checks++; if (read_ready !== '0) $display("FAIL reset_read_ready: got %b want 0000", read_ready); else passes++;
    checks++; if (write_ack !== '0) $display("FAIL reset_write_ack: got %b want 0000", write_ack); else passes++;
    checks++; if (data_out !== '0) $display("FAIL reset_data_out: got %h want 0000", data_out); else passes++;
    #2 reset = 1'b0;
    model_last = NP - 1;
    tick();
  endtask

  task automatic test_single_write_read();
    logic [DW-1:0] d;
    int lat;
    logic [2*NP-1:0] st;
    run_op(0, 1'b1, 5, 16'h1234, 16'h0000, d, lat, st);
    model_write(5, 16'h1234, 16'h0000);
    model_last = 0;
    checks++; if (lat !== 2) $display("FAIL single_wr_latency: got %0d want 2", lat); else passes++;
    checks++; if (st !== strobe_vec(1'b1, 0)) $display("FAIL single_wr_strobe: got %b want %b", st, strobe_vec(1'b1, 0)); else passes++;
    run_op(0, 1'b0, 5, 16'h0000, 16'h0000, d, lat, st);
    checks++; if (lat !== 2) $display("FAIL single_rd_latency: got %0d want 2", lat); else passes++;
    checks++; if (st !== strobe_vec(1'b0, 0)) $display("FAIL single_rd_strobe: got %b want %b", st, strobe_vec(1'b0, 0)); else passes++;
    checks++; if (d !== model_read(5)) $display("FAIL single_rd_data: got %h want %h", d, model_read(5)); else passes++;
  endtask

  task automatic test_accumulate();
    logic [DW-1:0] d;
    int lat;
    logic [2*NP-1:0] st;
    run_op(1, 1'b1, 7, 16'd10, 16'd0, d, lat, st);
    model_write(7, 16'd10, 16'd0);
    checks++; if (st !== strobe_vec(1'b1, 1)) $display("FAIL acc_wr1_strobe: got %b want %b", st, strobe_vec(1'b1, 1)); else passes++;
    run_op(1, 1'b1, 7, 16'hFFFF, 16'd1, d, lat, st);
    model_write(7, 16'hFFFF, 16'd1);
    checks++; if (st !== strobe_vec(1'b1, 1)) $display("FAIL acc_wr2_strobe: got %b want %b", st, strobe_vec(1'b1, 1)); else passes++;
    run_op(1, 1'b0, 7, 16'd0, 16'd0, d, lat, st);
    model_last = 1;
    checks++; if (d !== model_read(7)) $display("FAIL acc_rd_data: got %h want %h", d, model_read(7)); else passes++;
    checks++; if (lat !== 2) $display("FAIL acc_rd_latency: got %0d want 2", lat); else passes++;
  endtask

  task automatic test_round_robin();
    logic [DW-1:0] d;
    logic [DW-1:0] v;
    int lat;
    logic [2*NP-1:0] st;
    int seen;
    int prev_t;
    int g;
    for (int p = 0; p < NP; p++) begin
      v = DW'($urandom);
      run_op(2, 1'b1, 20 + p, v, 16'd0, d, lat, st);
      model_write(20 + p, v, 16'd0);
    end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_last = NP - 1;
    for (int p = 0; p < NP; p++) drive(p, 1'b1, 1'b0, 20 + p, '0, '0);
    seen   = 0;
    prev_t = 0;
    for (int t = 1; t <= 40 && seen < 8; t++) begin
      tick();
      if ((read_ready | write_ack) != '0) begin
        g = next_grant(read_req | write_req, model_last);
        checks++;
        if ({write_ack, read_ready} !== strobe_vec(1'b0, g))
          $display("FAIL rr_grant_%0d: got %b want %b", seen, {write_ack, read_ready}, strobe_vec(1'b0, g));
        else passes++;
        checks++;
        if (data_out !== model_read(20 + g))
          $display("FAIL rr_data_%0d: got %h want %h", seen, data_out, model_read(20 + g));
        else passes++;
        checks++;
        if ((t - prev_t) !== ((seen == 0) ? 2 : 3))
          $display("FAIL rr_spacing_%0d: got %0d want %0d", seen, t - prev_t, (seen == 0) ? 2 : 3);
        else passes++;
        prev_t     = t;
        model_last = g;
        seen++;
      end
    end
    checks++; if (seen !== 8) $display("FAIL rr_count: got %0d want 8", seen); else passes++;
    read_req = '0;
  endtask

  task automatic test_enable_stall();
    bit to;
    bit got;
    logic [DW-1:0] exp_d;
    wait_idle(to);
    checks++; if (to) $display("FAIL stall_idle_timeout: got busy want idle"); else passes++;
    exp_d = model_read(21);
    drive(1, 1'b1, 1'b0, 21, '0, '0);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      if (read_ready != '0) got = 1'b1;
    end
    checks++; if (!got) $display("FAIL stall_strobe_timeout: got none want read_ready"); else passes++;
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (read_ready !== 4'b0010) $display("FAIL stall_ready_%0d: got %b want 0010", i, read_ready); else passes++;
      checks++;
      if (data_out !== exp_d) $display("FAIL stall_data_%0d: got %h want %h", i, data_out, exp_d); else passes++;
    end
    enable   = 1'b1;
    read_req = '0;
    model_last = 1;
    tick();
    checks++; if (read_ready !== '0 || busy !== 1'b0) $display("FAIL stall_release: got rr=%b busy=%b want 0000 0", read_ready, busy); else passes++;
    checks++; if (data_out !== exp_d) $display("FAIL stall_data_hold: got %h want %h", data_out, exp_d); else passes++;
  endtask

  task automatic test_out_of_range();
    logic [DW-1:0] d;
    int lat;
    logic [2*NP-1:0] st;
    int hs[3] = '{199, 200, 250};
    logic [DW-1:0] v;
    for (int k = 0; k < 3; k++) begin
      v = DW'($urandom_range(1, 65535));
      run_op(3, 1'b1, hs[k], v, 16'd0, d, lat, st);
      model_write(hs[k], v, 16'd0);
      checks++;
      if (st !== strobe_vec(1'b1, 3)) $display("FAIL oor_wr_ack_h%0d: got %b want %b", hs[k], st, strobe_vec(1'b1, 3)); else passes++;
      run_op(3, 1'b0, hs[k], 16'd0, 16'd0, d, lat, st);
      checks++;
      if (st !== strobe_vec(1'b0, 3)) $display("FAIL oor_rd_ready_h%0d: got %b want %b", hs[k], st, strobe_vec(1'b0, 3)); else passes++;
      checks++;
      if (d !== model_read(hs[k])) $display("FAIL oor_rd_data_h%0d: got %h want %h", hs[k], d, model_read(hs[k])); else passes++;
    end
    model_last = 3;
  endtask

  task automatic test_random();
    bit to;
    logic [NP-1:0] mask;
    int hh[NP];
    logic [DW-1:0] aa[NP];
    logic [DW-1:0] bb[NP];
    bit rd;
    bit wr;
    int g;
    int pool[7] = '{3, 9, 17, 21, 199, 200, 250};
    for (int r = 0; r < 30; r++) begin
      wait_idle(to);
      checks++; if (to) $display("FAIL rand_idle_timeout_%0d: got busy want idle", r); else passes++;
      mask = NP'($urandom_range(1, 15));
      for (int p = 0; p < NP; p++) begin
        if (mask[pidx_t'(p)]) begin
          hh[p] = pool[$urandom_range(0, 6)];
          aa[p] = DW'($urandom);
          bb[p] = ($urandom_range(0, 1) == 1) ? DW'($urandom_range(1, 3)) : '0;
          wr    = ($urandom_range(0, 1) == 1);
          rd    = !wr || ($urandom_range(0, 3) == 0);
          if (hh[p] < NH && !model_valid[8'(hh[p])]) begin
            bb[p] = '0;
            if (!wr) begin
              wr = 1'b1;
              rd = 1'b0;
            end
          end
          drive(p, rd, wr, hh[p], aa[p], bb[p]);
        end else begin
          drive(p, 1'b0, 1'b0, $urandom_range(0, 255), DW'($urandom), DW'($urandom));
        end
      end
      for (int i = 0; i < 60 && (read_req | write_req) != '0; i++) begin
        tick();
        if ((read_ready | write_ack) != '0) begin
          g = next_grant(read_req | write_req, model_last);
          checks++;
          if ({write_ack, read_ready} !== strobe_vec(write_req[pidx_t'(g)], g))
            $display("FAIL rand_strobe_r%0d: got %b want %b", r, {write_ack, read_ready}, strobe_vec(write_req[pidx_t'(g)], g));
          else passes++;
          if (write_req[pidx_t'(g)]) begin
            model_write(hh[g], aa[g], bb[g]);
            write_req[pidx_t'(g)] = 1'b0;
          end else begin
            checks++;
            if (data_out !== model_read(hh[g]))
              $display("FAIL rand_data_r%0d: got %h want %h (h=%0d)", r, data_out, model_read(hh[g]), hh[g]);
            else passes++;
            read_req[pidx_t'(g)] = 1'b0;
          end
          model_last = g;
        end
        for (int p = 0; p < NP; p++) begin
          if (!read_req[pidx_t'(p)] && !write_req[pidx_t'(p)])
            drive(p, 1'b0, 1'b0, $urandom_range(0, 255), DW'($urandom), DW'($urandom));
        end
      end
      checks++; if ((read_req | write_req) != '0) $display("FAIL rand_drain_r%0d: got pending %b want 0000", r, read_req | write_req); else passes++;
      read_req  = '0;
      write_req = '0;
    end
  endtask

  task automatic test_async_reset();
    logic [DW-1:0] d;
    int lat;
    logic [2*NP-1:0] st;
    bit to;
    bit got;
    run_op(3, 1'b1, 9, 16'hBEEF, 16'd0, d, lat, st);
    model_write(9, 16'hBEEF, 16'd0);
    wait_idle(to);
    checks++; if (to) $display("FAIL areset_idle_timeout: got busy want idle"); else passes++;
    drive(2, 1'b0, 1'b1, 9, 16'h5A5A, 16'd0);
    tick();
    checks++; if (busy !== 1'b1) $display("FAIL areset_pre_busy: got %b want 1", busy); else passes++;
    #2 reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL areset_busy: got %b want 0", busy); else passes++;
    checks++; if ((read_ready | write_ack) !== '0) $display("FAIL areset_strobes: got %b want 0000", read_ready | write_ack); else passes++;
    checks++; if (data_out !== '0) $display("FAIL areset_data: got %h want 0000", data_out); else passes++;
    write_req = '0;
    tick();
    reset = 1'b0;
    model_last = NP - 1;
    for (int p = 0; p < NP; p++) drive(p, 1'b1, 1'b0, 9, '0, '0);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      if ((read_ready | write_ack) != '0) begin
        got = 1'b1;
        g_check: begin
          int g;
          g = next_grant(read_req | write_req, model_last);
          checks++;
          if ({write_ack, read_ready} !== strobe_vec(1'b0, g))
            $display("FAIL areset_first_grant: got %b want %b", {write_ack, read_ready}, strobe_vec(1'b0, g));
          else passes++;
          checks++;
          if (data_out !== model_read(9)) $display("FAIL areset_dropped_write: got %h want %h", data_out, model_read(9)); else passes++;
          model_last = g;
        end
        read_req = '0;
      end
    end
    checks++; if (!got) $display("FAIL areset_grant_timeout: got none want read_ready"); else passes++;
  endtask

  initial begin
    test_reset();
    test_single_write_read();
    test_accumulate();
    test_round_robin();
    test_enable_stall();
    test_out_of_range();
    test_random();
    test_async_reset();
    repeat (3) tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
